// File: rtl/demux1to16_seq.sv
// Serial-to-parallel 1:N demultiplexer: rebuilds N-bit frames from a slot-scanned
// serial stream aligned by a start-of-frame marker on slot 0.
module demux1to16_seq #(
    parameter int unsigned N    = 16,
    parameter int unsigned SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    input  logic            din_valid,
    input  logic            sof,
    output logic [SELW-1:0] slot,
    output logic            busy,
    output logic [N-1:0]    dout,
    output logic            dout_valid,
    output logic            frame_err
);

    localparam logic [SELW-1:0] LAST_SLOT = SELW'(N - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SELW-1:0] slot_q, slot_d;
    logic [N-2:0]    shadow_q, shadow_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            frame_err_q, frame_err_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (din_valid && sof) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (din_valid && !sof && slot_q == LAST_SLOT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot, shadow and frame output updates
    always_comb begin
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (sof) begin
                        shadow_d[0] = din;
                        slot_d      = SELW'(1);
                    end
                end
                CAPTURE: begin
                    if (sof) begin
                        // Restart: stale shadow bits get overwritten before completion
                        frame_err_d = 1'b1;
                        shadow_d[0] = din;
                        slot_d      = SELW'(1);
                    end else if (slot_q == LAST_SLOT) begin
                        dout_d       = {din, shadow_q};
                        dout_valid_d = 1'b1;
                        slot_d       = '0;
                    end else begin
                        for (int unsigned k = 0; k < N - 1; k++) begin
                            if (slot_q == SELW'(k)) shadow_d[k] = din;
                        end
                        slot_d = slot_q + SELW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign slot       = slot_q;
    assign busy       = (state_q == CAPTURE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_demux1to16_seq.sv
// Bench for demux1to16_seq: scenario tasks with a timed scoreboard of completed frames.
module tb_demux1to16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        sof;
    logic [3:0]  slot;
    logic        busy;
    logic [15:0] dout;
    logic        dout_valid;
    logic        frame_err;

    typedef struct {
        logic [15:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cycle_cnt = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    demux1to16_seq #(.N(16), .SELW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .slot      (slot),
        .busy      (busy),
        .dout      (dout),
        .dout_valid(dout_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Scoreboard: each completion must match the next expected frame and arrive on its due cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_checks++;
            if (dout_valid && frame_err) begin
                n_fail++;
                $display("FAIL excl: dout_valid=%b frame_err=%b, required not both", dout_valid, frame_err);
            end
            if (dout_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: dout=%h at cycle %0d, no frame expected", dout, cycle_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (dout !== e.data || cycle_cnt != e.due) begin
                        n_fail++;
                        $display("FAIL frame: dout=%h at cycle %0d, required %h at cycle %0d",
                                 dout, cycle_cnt, e.data, e.due);
                    end
                end
            end else if (sb_q.size() != 0 && sb_q[0].due < cycle_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_valid: frame %h due cycle %0d not seen by cycle %0d",
                         sb_q[0].data, sb_q[0].due, cycle_cnt);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic d, input logic v, input logic s);
        din       = d;
        din_valid = v;
        sof       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] f);
        exp_t e;
        e.data = f;
        e.due  = cycle_cnt + 1;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_frame(f);
            cyc(f[i], 1'b1, i == 0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'($urandom), 1'b1, 1'b1);
        cyc(1'($urandom), 1'b1, 1'b0);
        n_checks++;
        if (slot !== 4'd0 || busy !== 1'b0 || dout !== 16'h0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: slot=%0d busy=%b dout=%h dv=%b fe=%b, required all zero",
                     slot, busy, dout, dout_valid, frame_err);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_frame;
        logic [15:0] f = 16'hA5C3;
        n_checks++;
        if (slot !== 4'd0) begin
            n_fail++;
            $display("FAIL single_slot_start: slot=%0d, required 0", slot);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_frame(f);
            cyc(f[i], 1'b1, i == 0);
            n_checks++;
            if (slot !== 4'((i + 1) % 16) || busy !== (i != 15) || frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL single_beat%0d: slot=%0d busy=%b fe=%b, required slot=%0d busy=%b fe=0",
                         i, slot, busy, frame_err, (i + 1) % 16, (i != 15));
            end
        end
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== f) begin
            n_fail++;
            $display("FAIL single_latency: dv=%b dout=%h, required dv=1 dout=%h", dout_valid, dout, f);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gapped;
        logic [15:0] f = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_frame(f);
            cyc(f[i], 1'b1, i == 0);
            if (i == 4 || i == 11) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'($urandom), 1'b0, 1'($urandom));
                    n_checks++;
                    if (slot !== 4'(i + 1) || busy !== 1'b1 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL gap_hold%0d_%0d: slot=%0d busy=%b dv=%b fe=%b, required slot=%0d busy=1",
                                 i, g, slot, busy, dout_valid, frame_err, i + 1);
                    end
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_resync;
        logic [15:0] a = 16'hA5C3;
        logic [15:0] g = 16'h1234;
        for (int i = 0; i < 7; i++) cyc(a[i], 1'b1, i == 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_frame(g);
            cyc(g[i], 1'b1, i == 0);
            if (i == 0) begin
                n_checks++;
                if (frame_err !== 1'b1 || slot !== 4'd1 || dout !== a || dout_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL resync_err: fe=%b slot=%0d dout=%h dv=%b, required fe=1 slot=1 dout=%h dv=0",
                             frame_err, slot, dout, dout_valid, a);
                end
            end else if (i < 15) begin
                n_checks++;
                if (frame_err !== 1'b0 || dout !== a) begin
                    n_fail++;
                    $display("FAIL resync_hold%0d: fe=%b dout=%h, required fe=0 dout=%h", i, frame_err, dout, a);
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_orphans;
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom), 1'b1, 1'b0);
            n_checks++;
            if (busy !== 1'b0 || slot !== 4'd0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL orphan%0d: busy=%b slot=%0d dv=%b fe=%b, required all zero",
                         i, busy, slot, dout_valid, frame_err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int unsigned t1;
        int unsigned t2;
        send_frame(16'hFFFF);
        t1 = cycle_cnt;
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL b2b_first: dv=%b dout=%h, required dv=1 dout=ffff", dout_valid, dout);
        end
        send_frame(16'h0001);
        t2 = cycle_cnt;
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 16'h0001 || t2 - t1 != 16) begin
            n_fail++;
            $display("FAIL b2b_second: dv=%b dout=%h spacing=%0d, required dv=1 dout=0001 spacing=16",
                     dout_valid, dout, t2 - t1);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe;
        logic [15:0] a = 16'h5A5A;
        logic [15:0] g = 16'h8001;
        for (int i = 0; i < 9; i++) cyc(a[i], 1'b1, i == 0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        n_checks++;
        if (dout !== 16'h0 || slot !== 4'd0 || busy !== 1'b0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: dout=%h slot=%0d busy=%b dv=%b fe=%b, required all zero",
                     dout, slot, busy, dout_valid, frame_err);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_frame(g);
            cyc(g[i], 1'b1, i == 0);
            n_checks++;
            if (frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_fe%0d: fe=%b, required 0", i, frame_err);
            end
        end
        n_checks++;
        if (dout !== g) begin
            n_fail++;
            $display("FAIL rst_mid_frame: dout=%h, required %h", dout, g);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        test_reset();
        test_single_frame();
        test_gapped();
        test_resync();
        test_orphans();
        test_back_to_back();
        test_reset_midframe();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d frames outstanding, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1to16_seq.md
Name: demux1to16_seq

Overview:
- Serial-to-parallel 1-to-N demultiplexer: the receiving end of the 16:1 mux path.
- An upstream N:1 mux scans its select 0..N-1, one bit per valid beat; this block routes each beat back to its own output lane.
- Frame alignment comes from a start-of-frame marker on slot 0.
- A completed N-bit frame is presented on a registered parallel bus with a one-cycle valid pulse.

Parameters:
N, 16, number of output lanes (slots per frame); N >= 2
SELW, 4, slot index width; must satisfy 2**SELW >= N

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
din  input  1  serial data bit for the current slot
din_valid  input  1  din (and sof) valid this cycle
sof  input  1  start of frame; qualified by din_valid; marks the slot-0 bit
slot  output  SELW  index of the lane the next valid beat is written to; mirrors upstream mux sel
busy  output  1  high while a frame is partially captured (state CAPTURE)
dout  output  N  last completed frame; dout[k] = bit received in slot k
dout_valid  output  1  one-cycle pulse: dout updated this cycle
frame_err  output  1  one-cycle pulse: sof arrived mid-frame and the partial frame was discarded

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; slot=0; shadow=0; dout=0; dout_valid=0; frame_err=0; busy=0.
  - Reset overrides all inputs in the same cycle.
  - Reset mid-frame discards the partial frame; dout keeps no old value (it is 0).
- Internal shadow register, N-1 bits, holds slots 0..N-2 of the frame in progress.
- dout_valid and frame_err default to 0 every cycle unless set below. All outputs are registered.
- State IDLE (slot=0, busy=0):
  - din_valid=1 and sof=1: shadow[0]<=din; slot<=1; go to CAPTURE.
  - din_valid=1 and sof=0: beat dropped silently; no error; stay in IDLE.
  - din_valid=0: hold.
- State CAPTURE (busy=1, slot = k with 1 <= k <= N-1):
  - din_valid=0: hold all state; gaps of any length are allowed.
  - din_valid=1, sof=0, k<N-1: shadow[k]<=din; slot<=k+1.
  - din_valid=1, sof=0, k=N-1: dout<={din, shadow[N-2:0]}; dout_valid<=1; slot<=0; go to IDLE.
    - Latency: dout/dout_valid are visible the cycle after the last beat is sampled.
  - din_valid=1, sof=1 (any k, including N-1): frame_err<=1; partial frame discarded; shadow[0]<=din; slot<=1; stay in CAPTURE.
    - dout is unchanged and dout_valid=0 in this case.
- Back-to-back frames: a sof beat in the cycle after completion starts the next frame with no bubble. dout_valid for frame n and the slot-0 capture of frame n+1 may occur in the same cycle.
- dout_valid and frame_err are never asserted in the same cycle.
- slot never exceeds N-1. It wraps to 0 only on completion, reset, or IDLE; sof restart sets it to 1.
- Stale shadow bits are always overwritten before use, so they need no clearing on restart.
- sof with din_valid=0 is ignored.

Test Plan:
- Reset then one frame: sof on beat 0, din pattern 0xA5C3 sent LSB-first over 16 consecutive valid beats -> dout=0xA5C3 and dout_valid=1 exactly one cycle after beat 15; slot reads 0..15 then 0; frame_err stays 0.
- Gapped frame: same frame, din_valid low for 3 cycles after beats 4 and 11 -> dout=0xA5C3; slot holds during the gaps; dout_valid pulses once.
- Mid-frame resync: 7 beats, then sof with a fresh frame 0x1234 -> frame_err pulse in the cycle after the sof beat; the following completion gives dout=0x1234; dout is unchanged until then.
- Orphan beats: 5 valid beats with sof=0 in IDLE -> busy=0, slot=0, no dout_valid, no frame_err.
- Back-to-back: frames 0xFFFF then 0x0001 with no idle cycle -> two dout_valid pulses exactly 16 cycles apart with the correct values.
- Reset mid-frame: rst at beat 9 of a frame, then a new frame 0x8001 -> dout=0 right after reset, then 0x8001; no frame_err.
